// File: rtl/grid_path_host.sv
// Host-side sequencer for a grid path engine: streams the weight buffer,
// then checks the returned path beats for legality and records the result.
module grid_path_host #(
    parameter int N_CELLS = 24,
    parameter int TIMEOUT = 64,
    parameter int N_STEPS = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LD_VALID,
    input  logic [7:0]  LD_DATA,
    input  logic        START,
    output logic        IN_VALID,
    output logic [7:0]  IN_DATA,
    input  logic        OUT_VALID,
    input  logic [3:0]  OUT_DATA_X,
    input  logic [3:0]  OUT_DATA_Y,
    input  logic [15:0] OUT_DATA_SUM,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [1:0]  ERR_CODE,
    output logic [15:0] FINAL_SUM,
    output logic [3:0]  STEP_COUNT
);

    localparam int PW = $clog2(N_CELLS + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] CELLS = PW'(N_CELLS);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
    // A monotone path to the far corner of a square grid takes N_STEPS moves.
    localparam logic [3:0] GOAL = 4'(N_STEPS / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    state_t        state;
    logic [7:0]    buffer [N_CELLS];
    logic [PW-1:0] ld_ptr;
    logic [PW-1:0] send_idx;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    px;
    logic [3:0]    py;

    logic step_right;
    logic step_down;
    logic legal;
    logic at_goal;

    assign step_right = ({1'b0, OUT_DATA_X} == {1'b0, px} + 5'd1)
                        && (OUT_DATA_Y == py);
    assign step_down  = (OUT_DATA_X == px)
                        && ({1'b0, OUT_DATA_Y} == {1'b0, py} + 5'd1);
    assign legal      = (step_right || step_down)
                        && (OUT_DATA_SUM >= FINAL_SUM);
    assign at_goal    = (OUT_DATA_X == GOAL) && (OUT_DATA_Y == GOAL);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            IN_VALID   <= 1'b0;
            IN_DATA    <= 8'd0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CODE   <= 2'd0;
            FINAL_SUM  <= 16'd0;
            STEP_COUNT <= 4'd0;
            ld_ptr     <= '0;
            send_idx   <= '0;
            wait_cnt   <= '0;
            px         <= 4'd0;
            py         <= 4'd0;
            for (int i = 0; i < N_CELLS; i++) buffer[i] <= 8'd0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state      <= S_SEND;
                        BUSY       <= 1'b1;
                        DONE       <= 1'b0;
                        PASS       <= 1'b0;
                        ERR_CODE   <= 2'd0;
                        FINAL_SUM  <= 16'd0;
                        STEP_COUNT <= 4'd0;
                        ld_ptr     <= '0;
                        px         <= 4'd0;
                        py         <= 4'd0;
                        wait_cnt   <= '0;
                        IN_VALID   <= 1'b1;
                        IN_DATA    <= buffer[0];
                        send_idx   <= PW'(1);
                    end else if (LD_VALID && ld_ptr < CELLS) begin
                        buffer[ld_ptr] <= LD_DATA;
                        ld_ptr         <= ld_ptr + PW'(1);
                    end
                end
                S_SEND: begin
                    if (send_idx == CELLS) begin
                        IN_VALID <= 1'b0;
                        IN_DATA  <= 8'd0;
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        IN_DATA  <= buffer[send_idx];
                        send_idx <= send_idx + PW'(1);
                    end
                end
                S_WAIT, S_RECV: begin
                    if (OUT_VALID) begin
                        if (legal) begin
                            px        <= OUT_DATA_X;
                            py        <= OUT_DATA_Y;
                            FINAL_SUM <= OUT_DATA_SUM;
                            if (STEP_COUNT != 4'd15)
                                STEP_COUNT <= STEP_COUNT + 4'd1;
                            if (at_goal) begin
                                state <= S_DONE;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                                PASS  <= 1'b1;
                            end else begin
                                state <= S_RECV;
                            end
                        end else begin
                            state    <= S_DONE;
                            BUSY     <= 1'b0;
                            DONE     <= 1'b1;
                            ERR_CODE <= 2'd1;
                        end
                    end else if (state == S_RECV) begin
                        // The engine must stream beats back-to-back once started.
                        state    <= S_DONE;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        ERR_CODE <= 2'd2;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state    <= S_DONE;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        ERR_CODE <= 2'd3;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_path_host.sv
// Directed bench for grid_path_host: load/stream, legal path,
// illegal step, premature end, timeout and mid-run reset.
module tb_grid_path_host;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        LD_VALID = 1'b0;
    logic [7:0]  LD_DATA = 8'd0;
    logic        START = 1'b0;
    logic        IN_VALID;
    logic [7:0]  IN_DATA;
    logic        OUT_VALID = 1'b0;
    logic [3:0]  OUT_DATA_X = 4'd0;
    logic [3:0]  OUT_DATA_Y = 4'd0;
    logic [15:0] OUT_DATA_SUM = 16'd0;
    logic        BUSY;
    logic        DONE;
    logic        PASS;
    logic [1:0]  ERR_CODE;
    logic [15:0] FINAL_SUM;
    logic [3:0]  STEP_COUNT;

    int total = 0;
    int bad = 0;

    grid_path_host dut (
        .CLK(CLK), .RESET(RESET),
        .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .START(START),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_DATA_X(OUT_DATA_X),
        .OUT_DATA_Y(OUT_DATA_Y), .OUT_DATA_SUM(OUT_DATA_SUM),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CODE(ERR_CODE),
        .FINAL_SUM(FINAL_SUM), .STEP_COUNT(STEP_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input int x, input int y, input int s);
        OUT_VALID = 1'b1;
        OUT_DATA_X = 4'(x);
        OUT_DATA_Y = 4'(y);
        OUT_DATA_SUM = 16'(s);
        tick();
        OUT_VALID = 1'b0;
    endtask

    // START pulse plus the 24 streaming cycles; leaves the DUT in WAIT
    task automatic run_send();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (24) tick();
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({IN_VALID, IN_DATA, BUSY, DONE, PASS, ERR_CODE, FINAL_SUM, STEP_COUNT} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                {IN_VALID, IN_DATA, BUSY, DONE, PASS, ERR_CODE, FINAL_SUM, STEP_COUNT});
        end
        tick();
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_send();
        for (int i = 0; i < 24; i++) begin
            LD_VALID = 1'b1;
            LD_DATA = 8'(i + 1);
            tick();
        end
        LD_DATA = 8'hAA;
        tick();
        LD_VALID = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < 24; k++) begin
            total++;
            if (IN_VALID !== 1'b1 || IN_DATA !== 8'(k + 1) || BUSY !== 1'b1) begin
                bad++;
                $display("FAIL send_beat%0d got v=%b d=%0d b=%b required v=1 d=%0d b=1",
                    k, IN_VALID, IN_DATA, BUSY, k + 1);
            end
            START = (k == 5);
            tick();
        end
        START = 1'b0;
        total++;
        if (IN_VALID !== 1'b0 || IN_DATA !== 8'd0 || BUSY !== 1'b1 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL send_end got v=%b d=%0d b=%b dn=%b required v=0 d=0 b=1 dn=0",
                IN_VALID, IN_DATA, BUSY, DONE);
        end
    endtask

    task automatic test_path();
        int xs[8] = '{1, 2, 3, 4, 4, 4, 4, 4};
        int ys[8] = '{0, 0, 0, 0, 1, 2, 3, 4};
        for (int j = 0; j < 8; j++) begin
            total++;
            if (DONE !== 1'b0) begin
                bad++;
                $display("FAIL path_early_done beat=%0d got=%b required=0", j, DONE);
            end
            beat(xs[j], ys[j], j + 1);
        end
        total++;
        if (DONE !== 1 || PASS !== 1 || ERR_CODE !== 0 || FINAL_SUM !== 8
            || STEP_COUNT !== 8 || BUSY !== 0) begin
            bad++;
            $display("FAIL path_result got dn=%b p=%b e=%0d s=%0d c=%0d b=%b required 1 1 0 8 8 0",
                DONE, PASS, ERR_CODE, FINAL_SUM, STEP_COUNT, BUSY);
        end
        beat(5, 4, 20);
        tick();
        total++;
        if (DONE !== 1 || PASS !== 1 || FINAL_SUM !== 8 || STEP_COUNT !== 8) begin
            bad++;
            $display("FAIL path_after_done got dn=%b p=%b s=%0d c=%0d required 1 1 8 8",
                DONE, PASS, FINAL_SUM, STEP_COUNT);
        end
    endtask

    task automatic test_illegal();
        run_send();
        total++;
        if (ERR_CODE !== 0 || FINAL_SUM !== 0 || STEP_COUNT !== 0 || DONE !== 0) begin
            bad++;
            $display("FAIL restart_clear got e=%0d s=%0d c=%0d dn=%b required 0 0 0 0",
                ERR_CODE, FINAL_SUM, STEP_COUNT, DONE);
        end
        beat(2, 0, 3);
        total++;
        if (ERR_CODE !== 1 || PASS !== 0 || DONE !== 1 || STEP_COUNT !== 0) begin
            bad++;
            $display("FAIL illegal_step got e=%0d p=%b dn=%b c=%0d required 1 0 1 0",
                ERR_CODE, PASS, DONE, STEP_COUNT);
        end
        run_send();
        beat(1, 0, 5);
        beat(1, 1, 4);
        total++;
        if (ERR_CODE !== 1 || DONE !== 1 || STEP_COUNT !== 1 || FINAL_SUM !== 5) begin
            bad++;
            $display("FAIL sum_decrease got e=%0d dn=%b c=%0d s=%0d required 1 1 1 5",
                ERR_CODE, DONE, STEP_COUNT, FINAL_SUM);
        end
    endtask

    task automatic test_premature();
        run_send();
        beat(1, 0, 1);
        beat(2, 0, 2);
        beat(3, 0, 3);
        total++;
        if (DONE !== 0 || BUSY !== 1) begin
            bad++;
            $display("FAIL premature_busy got dn=%b b=%b required 0 1", DONE, BUSY);
        end
        tick();
        total++;
        if (ERR_CODE !== 2 || DONE !== 1 || STEP_COUNT !== 3 || FINAL_SUM !== 3 || PASS !== 0) begin
            bad++;
            $display("FAIL premature_end got e=%0d dn=%b c=%0d s=%0d p=%b required 2 1 3 3 0",
                ERR_CODE, DONE, STEP_COUNT, FINAL_SUM, PASS);
        end
        beat(4, 0, 9);
        tick();
        total++;
        if (ERR_CODE !== 2 || STEP_COUNT !== 3) begin
            bad++;
            $display("FAIL first_error_held got e=%0d c=%0d required 2 3", ERR_CODE, STEP_COUNT);
        end
    endtask

    task automatic test_timeout();
        run_send();
        repeat (63) tick();
        total++;
        if (DONE !== 0 || BUSY !== 1) begin
            bad++;
            $display("FAIL timeout_early got dn=%b b=%b required 0 1", DONE, BUSY);
        end
        tick();
        total++;
        if (DONE !== 1 || ERR_CODE !== 3 || PASS !== 0 || BUSY !== 0) begin
            bad++;
            $display("FAIL timeout got dn=%b e=%0d p=%b b=%b required 1 3 0 0",
                DONE, ERR_CODE, PASS, BUSY);
        end
    endtask

    task automatic test_reset_mid_send();
        bit saw_done = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (10) tick();
        total++;
        if (IN_VALID !== 1 || IN_DATA !== 8'd11) begin
            bad++;
            $display("FAIL send_cycle10 got v=%b d=%0d required 1 11", IN_VALID, IN_DATA);
        end
        RESET = 1'b0;
        #1;
        total++;
        if (IN_VALID !== 0 || IN_DATA !== 0 || BUSY !== 0 || DONE !== 0) begin
            bad++;
            $display("FAIL reset_mid_send got v=%b d=%0d b=%b dn=%b required 0 0 0 0",
                IN_VALID, IN_DATA, BUSY, DONE);
        end
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (DONE !== 0 || PASS !== 0 || BUSY !== 0) saw_done = 1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL post_reset_idle got activity=1 required 0");
        end
        START = 1'b1;
        tick();
        START = 1'b0;
        total++;
        if (IN_VALID !== 1 || IN_DATA !== 8'd0) begin
            bad++;
            $display("FAIL buffer_cleared got v=%b d=%0d required 1 0", IN_VALID, IN_DATA);
        end
    endtask

    initial begin
        test_reset();
        test_send();
        test_path();
        test_illegal();
        test_premature();
        test_timeout();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
